if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word inserted into IF/ID on flush or reset.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  is synchronous and active-high.
REQ-005 stall  input  1  is the hazard-unit hold request; it freezes the PC and IF/ID.
REQ-006 flush  input  1  squashes the IF/ID contents to NOP_INSTR.
REQ-007 redirect_en  input  1  is the branch/jump/jr redirect strobe from the ID/EX stages.
REQ-008 redirect_pc  input  32  is the redirect target byte address.
REQ-009 rom_addr  output  32  is the fetch address presented to the instruction ROM; it equals the PC register (combinational).
REQ-010 rom_data  input  32  is the combinational ROM read data for rom_addr.
REQ-011 ifid_instr  output  32  is the registered instruction passed to decode.
REQ-012 ifid_pc_plus4  output  32  is the registered PC+4 of ifid_instr.
REQ-013 ifid_valid  output  1  is high when ifid_instr is a real fetched instruction.
REQ-014 redirect_pending  output  1  is high while a redirect is latched awaiting stall release.

Function
REQ-015 The block SHALL hold a 32-bit PC register; rom_addr SHALL equal the PC with no added latency.
REQ-016 Normal cycle (no reset/stall/flush/redirect): pc<=pc+4; ifid_instr<=rom_data; ifid_pc_plus4<=pc+4; ifid_valid<=1.
REQ-017 pc+4 SHALL be 32-bit modular: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 Redirect targets SHALL be word-aligned by forcing bits [1:0] to 2'b00.
REQ-019 The FSM SHALL have two states: RUN and PEND.
REQ-020 RUN, redirect_en=1, stall=0: pc<=aligned redirect_pc; stay RUN.
REQ-021 RUN, redirect_en=1, stall=1: pc holds; pend_pc<=aligned redirect_pc; go to PEND.
REQ-022 PEND, stall=1: pc holds; a new redirect_en overwrites pend_pc; stay PEND.
REQ-023 PEND, stall=0, redirect_en=0: pc<=pend_pc; go to RUN.
REQ-024 PEND, stall=0, redirect_en=1: pc<=aligned redirect_pc (newest wins); go to RUN.
REQ-025 redirect_pending SHALL be 1 exactly in state PEND.
REQ-026 stall=1, flush=0: pc, ifid_instr, ifid_pc_plus4 and ifid_valid SHALL hold.
REQ-027 flush=1 (with or without stall): ifid_instr<=NOP_INSTR; ifid_pc_plus4<=0; ifid_valid<=0. Flush has priority over stall for IF/ID only.
REQ-028 PC update SHALL be independent of flush; the redirect source asserts flush itself to kill the wrong-path fetch.
REQ-029 Priority SHALL be: reset > redirect/PEND resolution > stall > sequential increment.

Reset
REQ-030 On reset=1 at a clock edge: pc<=RESET_PC; state<=RUN; pend_pc<=0; ifid_instr<=NOP_INSTR; ifid_pc_plus4<=0; ifid_valid<=0.
REQ-031 Reset SHALL override stall, flush and redirect in the same cycle and SHALL discard any pending redirect.
REQ-032 In the first cycle after reset release, rom_addr SHALL be RESET_PC and ifid_valid SHALL be 0.

Structure
REQ-033 RESET_PC, NOP_INSTR and the RUN/PEND state encoding SHALL live in the shared CPU constants package.
REQ-034 The IF/ID register (instr, pc_plus4, valid, with hold and flush controls) SHALL be a sub-module named ifid_reg; the PC and FSM stay in if_stage.

Verification
REQ-035 Reset, then 3 free cycles with ROM word 0 = 32'h0800_002F -> rom_addr 0,4,8,C; ifid_instr=32'h0800_002F with ifid_pc_plus4=4, ifid_valid=1 after the first edge.
REQ-036 redirect_en=1, redirect_pc=32'h0000_00BE, flush=1 at pc=8 -> next pc=32'h0000_00BC; ifid_valid=0; ifid_instr=0.
REQ-037 stall=1 for 3 cycles at pc=0x10 -> rom_addr stays 0x10 and IF/ID unchanged; release -> pc=0x14.
REQ-038 stall=1 with redirect to 0x100, then redirect to 0x200 while still stalled; release -> redirect_pending 1 during stall, pc=0x200 after release, pending cleared.
REQ-039 PEND with reset=1 asserted -> pc=RESET_PC, redirect_pending=0, ifid_valid=0; no later jump to pend_pc.
REQ-040 pc forced to 32'hFFFF_FFFC, free-run -> next pc=0, ifid_pc_plus4=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared CPU constants for the fetch stage: reset/NOP values, fetch FSM states
// and the redirect-target alignment helper.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage buses: instruction ROM port and the IF/ID register outputs.
interface if_stage_if;

  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  modport master (
    output rom_addr,
    input  rom_data,
    output ifid_instr,
    output ifid_pc_plus4,
    output ifid_valid
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ifid_instr,
    input  ifid_pc_plus4,
    input  ifid_valid
  );

endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register; flush beats hold, reset beats everything.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (!hold) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect latch FSM (RUN/PEND) and the
// IF/ID register. A redirect arriving under stall is parked until release.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  output logic              redirect_pending,
  if_stage_if.master        bus
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  pend_pc, pend_pc_next;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;

  assign pc_plus4         = pc + 32'd4;
  assign target           = align_word(redirect_pc);
  assign bus.rom_addr     = pc;
  assign redirect_pending = (state == PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
    end
  end

  // Flush never touches the PC; the redirect source pairs flush with its own redirect.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    unique case (state)
      RUN: begin
        if (redirect_en) begin
          if (stall) begin
            pend_pc_next = target;
            state_next   = PEND;
          end else begin
            pc_next = target;
          end
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
      end
      PEND: begin
        if (stall) begin
          if (redirect_en) pend_pc_next = target;
        end else begin
          pc_next    = redirect_en ? target : pend_pc;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .hold       (stall),
    .flush      (flush),
    .instr_in   (bus.rom_data),
    .pc_plus4_in(pc_plus4),
    .instr      (bus.ifid_instr),
    .pc_plus4   (bus.ifid_pc_plus4),
    .valid      (bus.ifid_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        redirect_pending;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .redirect_pending(redirect_pending),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0800_002F;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  always_comb bus.rom_data = rom_word(bus.rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a parked redirect is just a flag plus a target.
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_target, m_instr, m_pp4;
  logic        m_pend, m_valid;

  always @(posedge clk) begin
    if (reset) begin
      m_known  <= 1'b1;
      m_pc     <= 32'h0;
      m_pend   <= 1'b0;
      m_target <= 32'h0;
      m_instr  <= 32'h0;
      m_pp4    <= 32'h0;
      m_valid  <= 1'b0;
    end else begin
      if (flush) begin
        m_instr <= 32'h0;
        m_pp4   <= 32'h0;
        m_valid <= 1'b0;
      end else if (!stall) begin
        m_instr <= rom_word(m_pc);
        m_pp4   <= m_pc + 32'd4;
        m_valid <= 1'b1;
      end
      if (!stall) begin
        m_pc   <= redirect_en ? (redirect_pc & ~32'h3) : (m_pend ? m_target : m_pc + 32'd4);
        m_pend <= 1'b0;
      end else if (redirect_en) begin
        m_pend   <= 1'b1;
        m_target <= redirect_pc & ~32'h3;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("rom_addr", bus.rom_addr, m_pc);
      check("ifid_instr", bus.ifid_instr, m_instr);
      check("ifid_pc_plus4", bus.ifid_pc_plus4, m_pp4);
      check("ifid_valid", {31'h0, bus.ifid_valid}, {31'h0, m_valid});
      check("redirect_pending", {31'h0, redirect_pending}, {31'h0, m_pend});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_rom_addr", bus.rom_addr, 32'h0);
    check("rst_valid", {31'h0, bus.ifid_valid}, 32'h0);
    check("rst_pending", {31'h0, redirect_pending}, 32'h0);

    // Free-running fetch from address 0
    tick();
    check("seq_addr4", bus.rom_addr, 32'h4);
    check("seq_instr", bus.ifid_instr, 32'h0800_002F);
    check("seq_pp4", bus.ifid_pc_plus4, 32'h4);
    check("seq_valid", {31'h0, bus.ifid_valid}, 32'h1);
    tick();
    check("seq_addr8", bus.rom_addr, 32'h8);

    // Redirect with flush at pc=8, misaligned target
    redirect_en = 1'b1; redirect_pc = 32'h0000_00BE; flush = 1'b1;
    tick(); idle();
    check("redir_addr", bus.rom_addr, 32'h0000_00BC);
    check("redir_valid", {31'h0, bus.ifid_valid}, 32'h0);
    check("redir_instr", bus.ifid_instr, 32'h0);

    // Get to pc=0x10 holding a real instruction, then stall three cycles
    redirect_en = 1'b1; redirect_pc = 32'h0000_000C;
    tick(); idle();
    tick();
    check("pre_stall_addr", bus.rom_addr, 32'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", bus.rom_addr, 32'h10);
      check("stall_pp4", bus.ifid_pc_plus4, 32'h10);
      check("stall_instr", bus.ifid_instr, rom_word(32'hC));
    end
    stall = 1'b0;
    tick();
    check("release_addr", bus.rom_addr, 32'h14);

    // Two redirects while stalled: newest wins
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
    tick();
    check("pend_set", {31'h0, redirect_pending}, 32'h1);
    check("pend_addr_hold", bus.rom_addr, 32'h14);
    redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0;
    tick();
    check("pend_still", {31'h0, redirect_pending}, 32'h1);
    stall = 1'b0;
    tick();
    check("pend_resolve_addr", bus.rom_addr, 32'h200);
    check("pend_cleared", {31'h0, redirect_pending}, 32'h0);

    // Reset discards a parked redirect
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_en = 1'b0; reset = 1'b1;
    tick();
    check("rstpend_addr", bus.rom_addr, 32'h0);
    check("rstpend_pending", {31'h0, redirect_pending}, 32'h0);
    check("rstpend_valid", {31'h0, bus.ifid_valid}, 32'h0);
    idle();
    tick();
    check("rstpend_nojump", bus.rom_addr, 32'h4);

    // PC wrap at the top of the address space
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(); idle();
    check("wrap_top", bus.rom_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr", bus.rom_addr, 32'h0);
    check("wrap_pp4", bus.ifid_pc_plus4, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      stall       = ($urandom_range(0, 9) < 3);
      flush       = ($urandom_range(0, 99) < 15);
      redirect_en = ($urandom_range(0, 99) < 20);
      redirect_pc = $urandom;
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
